// File: rtl/deser_align_pkg.sv
// Shared state/error types and default constants for the lane alignment controller.
package deser_align_pkg;

    localparam int          TAP_W_DEF        = 5;
    localparam logic [23:0] SYNC_PATTERN_DEF = 24'hFFF000;
    localparam int          ROT_W            = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_SETTLE,
        S_CHECK,
        S_NEXT,
        S_CENTER,
        S_LOAD_FINAL,
        S_DONE,
        S_FAIL
    } align_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_EYE     = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_TAP     = 2'd3
    } err_code_t;

endpackage

// File: rtl/deser_word_match.sv
// Registered sync-pattern comparator for one recovered lane word.
// The rotation search exists only when DESER_ALIGN_ROTATE_EN is defined.
module deser_word_match
    import deser_align_pkg::*;
#(
    parameter int                   WORD_SIZE    = 24,
    parameter logic [WORD_SIZE-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sample,
    input  logic [WORD_SIZE-1:0] i_word,
    output logic                 o_vld,
    output logic                 o_match,
    output logic [ROT_W-1:0]     o_rot_idx
);

    logic             w_hit;
    logic [ROT_W-1:0] w_rot;

`ifdef DESER_ALIGN_ROTATE_EN
    logic [2*WORD_SIZE-1:0] w_dbl;

    // Scan downwards so the smallest matching left-rotation wins.
    always_comb begin
        w_dbl = {i_word, i_word};
        w_hit = 1'b0;
        w_rot = '0;
        for (int r = WORD_SIZE - 1; r >= 0; r--) begin
            if (w_dbl[2*WORD_SIZE-1-r -: WORD_SIZE] == SYNC_PATTERN) begin
                w_hit = 1'b1;
                w_rot = ROT_W'(r);
            end
        end
    end
`else
    assign w_hit = (i_word == SYNC_PATTERN);
    assign w_rot = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_vld     <= 1'b0;
            o_match   <= 1'b0;
            o_rot_idx <= '0;
        end else begin
            o_vld     <= i_sample;
            o_match   <= w_hit;
            o_rot_idx <= w_rot;
        end
    end

endmodule

// File: rtl/deser_lane_align_ctrl.sv
// IDELAY tap-sweep training controller for one deserializer lane; finds the widest
// passing eye and loads its centre. Optional word-rotation search: DESER_ALIGN_ROTATE_EN.
module deser_lane_align_ctrl
    import deser_align_pkg::*;
#(
    parameter int                   WORD_SIZE    = 24,
    parameter int                   TAP_W        = TAP_W_DEF,
    parameter logic [WORD_SIZE-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int                   SETTLE_WORDS = 8,
    parameter int                   CHECK_WORDS  = 16,
    parameter int                   MIN_EYE      = 4,
    parameter int                   TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 word_valid,
    input  logic [WORD_SIZE-1:0] data_in_to_device,
    input  logic [TAP_W-1:0]     in_delay_tap_out,
    output logic                 ld_dly_tap,
    output logic [TAP_W-1:0]     in_delay_tap_in,
    output logic                 in_delay_data_ce,
    output logic                 in_delay_data_inc,
    output logic                 busy,
    output logic                 locked,
    output logic                 fail,
    output logic [1:0]           err_code,
    output logic [TAP_W-1:0]     eye_start,
    output logic [TAP_W:0]       eye_len,
    output logic [ROT_W-1:0]     word_rot
);

    localparam int SW_W = $clog2(SETTLE_WORDS + 1);
    localparam int CW_W = $clog2(CHECK_WORDS + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TAP_W-1:0] TAP_MAX     = '1;
    localparam logic [SW_W-1:0]  SETTLE_LAST = SW_W'(SETTLE_WORDS - 1);
    localparam logic [CW_W-1:0]  CHECK_LAST  = CW_W'(CHECK_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT    = TO_W'(TIMEOUT);
    localparam logic [TAP_W:0]   MIN_LEN     = (TAP_W+1)'(MIN_EYE);
    localparam logic [TAP_W:0]   LEN_ONE     = (TAP_W+1)'(1);

    align_state_t     r_state, w_nxt;
    err_code_t        r_err;
    logic [TAP_W-1:0] r_tap;
    logic             r_final;
    logic [1:0]       r_vcnt;
    logic [SW_W-1:0]  r_set_cnt;
    logic [CW_W-1:0]  r_chk_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_pass;
    logic [ROT_W-1:0] r_chk_rot;
    logic [TAP_W:0]   r_run_len;
    logic [TAP_W-1:0] r_run_start;
    logic [ROT_W-1:0] r_run_rot;
    logic [TAP_W:0]   r_eye_len;
    logic [TAP_W-1:0] r_eye_start;
    logic [ROT_W-1:0] r_best_rot;
    logic [ROT_W-1:0] r_word_rot;
    logic             r_locked;
    logic             r_fail;

    logic             w_m_vld;
    logic             w_m_match;
    logic [ROT_W-1:0] w_m_rot;
    logic             w_word_ok;
    logic             w_to_exp;
    logic [TAP_W:0]   w_len_cl;
    logic [TAP_W-1:0] w_start_cl;
    logic [ROT_W-1:0] w_rot_cl;
    logic             w_open;
    logic             w_close;
    logic [TAP_W-1:0] w_final;

    deser_word_match #(
        .WORD_SIZE    (WORD_SIZE),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .i_sample  (word_valid && (r_state == S_CHECK)),
        .i_word    (data_in_to_device),
        .o_vld     (w_m_vld),
        .o_match   (w_m_match),
        .o_rot_idx (w_m_rot)
    );

    // Later words in a check must reuse the rotation fixed by the first word.
    assign w_word_ok = w_m_match && ((r_chk_cnt == '0) || (w_m_rot == r_chk_rot));
    assign w_to_exp  = !word_valid && (r_to_cnt == TO_LIMIT);
    // Eye never runs past tap 31, so the centre fits in TAP_W bits.
    assign w_final   = r_eye_start + r_eye_len[TAP_W:1];

    always_comb begin
        w_open     = r_pass && (r_run_len == '0);
        w_len_cl   = r_pass ? r_run_len + LEN_ONE : r_run_len;
        w_start_cl = w_open ? r_tap : r_run_start;
        w_rot_cl   = w_open ? r_chk_rot : r_run_rot;
        w_close    = !r_pass || (r_tap == TAP_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAIL: if (start) w_nxt = S_LOAD;
            S_LOAD, S_LOAD_FINAL:   w_nxt = S_VERIFY;
            S_VERIFY: begin
                if (r_vcnt == 2'd2) begin
                    if (in_delay_tap_out != r_tap) w_nxt = S_FAIL;
                    else if (r_final)              w_nxt = S_DONE;
                    else                           w_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_to_exp)                                    w_nxt = S_FAIL;
                else if (word_valid && (r_set_cnt == SETTLE_LAST)) w_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (w_to_exp) w_nxt = S_FAIL;
                else if (w_m_vld && (!w_word_ok || (r_chk_cnt == CHECK_LAST))) w_nxt = S_NEXT;
            end
            S_NEXT:   w_nxt = (r_tap == TAP_MAX) ? S_CENTER : S_LOAD;
            S_CENTER: w_nxt = (r_eye_len < MIN_LEN) ? S_FAIL : S_LOAD_FINAL;
            default:  w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err       <= ERR_NONE;
            r_tap       <= '0;
            r_final     <= 1'b0;
            r_vcnt      <= '0;
            r_set_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_to_cnt    <= '0;
            r_pass      <= 1'b0;
            r_chk_rot   <= '0;
            r_run_len   <= '0;
            r_run_start <= '0;
            r_run_rot   <= '0;
            r_eye_len   <= '0;
            r_eye_start <= '0;
            r_best_rot  <= '0;
            r_word_rot  <= '0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_err       <= ERR_NONE;
                        r_tap       <= '0;
                        r_final     <= 1'b0;
                        r_locked    <= 1'b0;
                        r_fail      <= 1'b0;
                        r_eye_len   <= '0;
                        r_eye_start <= '0;
                        r_best_rot  <= '0;
                        r_word_rot  <= '0;
                        r_run_len   <= '0;
                        r_run_start <= '0;
                        r_run_rot   <= '0;
                    end
                end
                S_LOAD, S_LOAD_FINAL: r_vcnt <= '0;
                S_VERIFY: begin
                    r_vcnt    <= r_vcnt + 2'd1;
                    r_set_cnt <= '0;
                    r_to_cnt  <= '0;
                    if (w_nxt == S_FAIL) begin
                        r_fail <= 1'b1;
                        r_err  <= ERR_TAP;
                    end
                    if (w_nxt == S_DONE) begin
                        r_locked   <= 1'b1;
                        r_word_rot <= r_best_rot;
                    end
                end
                S_SETTLE, S_CHECK: begin
                    r_to_cnt <= word_valid ? '0 : r_to_cnt + TO_W'(1);
                    if (w_nxt == S_FAIL) begin
                        r_fail <= 1'b1;
                        r_err  <= ERR_TIMEOUT;
                    end
                    if (r_state == S_SETTLE) begin
                        r_chk_cnt <= '0;
                        if (word_valid) r_set_cnt <= r_set_cnt + SW_W'(1);
                    end else if (w_m_vld) begin
                        r_chk_cnt <= r_chk_cnt + CW_W'(1);
                        if (r_chk_cnt == '0) r_chk_rot <= w_m_rot;
                        r_pass <= w_word_ok;
                    end
                end
                S_NEXT: begin
                    r_run_len   <= r_pass ? w_len_cl : '0;
                    r_run_start <= w_start_cl;
                    r_run_rot   <= w_rot_cl;
                    // Strictly longer only, so the earliest of equal windows survives.
                    if (w_close && (w_len_cl > r_eye_len)) begin
                        r_eye_len   <= w_len_cl;
                        r_eye_start <= w_start_cl;
                        r_best_rot  <= w_rot_cl;
                    end
                    if (r_tap != TAP_MAX) r_tap <= r_tap + TAP_W'(1);
                end
                S_CENTER: begin
                    if (w_nxt == S_FAIL) begin
                        r_fail <= 1'b1;
                        r_err  <= ERR_EYE;
                    end else begin
                        r_tap   <= w_final;
                        r_final <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by rst so a reset landing on a load cycle never reaches the IDELAY.
    assign ld_dly_tap        = !rst && ((r_state == S_LOAD) || (r_state == S_LOAD_FINAL));
    assign in_delay_tap_in   = r_tap;
    assign in_delay_data_ce  = 1'b0;
    assign in_delay_data_inc = 1'b0;
    assign busy              = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));
    assign locked            = r_locked;
    assign fail              = r_fail;
    assign err_code          = r_err;
    assign eye_start         = r_eye_start;
    assign eye_len           = r_eye_len;
    assign word_rot          = r_word_rot;

endmodule

// File: tb/tb_deser_lane_align_ctrl.sv
// Randomized bench for deser_lane_align_ctrl: lane model with a per-tap pass mask,
// reference eye search, load scoreboard, timeout / readback / reset cases.
module tb_deser_lane_align_ctrl;

    localparam logic [23:0] SYNC    = 24'hFFF000;
    localparam int          MIN_EYE = 4;
    localparam int          TIMEOUT = 4096;
`ifdef DESER_ALIGN_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        word_valid = 1'b0;
    logic [23:0] data_in_to_device = '0;
    logic [4:0]  in_delay_tap_out = '0;
    logic        ld_dly_tap;
    logic [4:0]  in_delay_tap_in;
    logic        in_delay_data_ce;
    logic        in_delay_data_inc;
    logic        busy;
    logic        locked;
    logic        fail;
    logic [1:0]  err_code;
    logic [4:0]  eye_start;
    logic [5:0]  eye_len;
    logic [4:0]  word_rot;

    logic [31:0] lane_mask = '0;
    int          lane_rot  = 0;
    bit          gen_en    = 1'b0;
    bit          dense     = 1'b0;
    bit          force_bad = 1'b0;
    logic [4:0]  tap_q     = '0;
    int          loads[$];
    int          n_chk = 0;
    int          n_err = 0;

    deser_lane_align_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .word_valid        (word_valid),
        .data_in_to_device (data_in_to_device),
        .in_delay_tap_out  (in_delay_tap_out),
        .ld_dly_tap        (ld_dly_tap),
        .in_delay_tap_in   (in_delay_tap_in),
        .in_delay_data_ce  (in_delay_data_ce),
        .in_delay_data_inc (in_delay_data_inc),
        .busy              (busy),
        .locked            (locked),
        .fail              (fail),
        .err_code          (err_code),
        .eye_start         (eye_start),
        .eye_len           (eye_len),
        .word_rot          (word_rot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rotr(input logic [23:0] w, input int r);
        logic [47:0] d;
        d = {w, w};
        return d[r +: 24];
    endfunction

    // Twelve ones is the only popcount any rotation of the pattern can have.
    function automatic logic [23:0] rand_bad();
        logic [23:0] w;
        w = 24'($urandom);
        if ($countones(w) == 12) w[0] = ~w[0];
        return w;
    endfunction

    // Lane model: IDELAY register with readback plus a word source keyed on the tap.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ld_dly_tap) begin
                loads.push_back(int'(in_delay_tap_in));
                tap_q = in_delay_tap_in;
            end
            in_delay_tap_out  = force_bad ? 5'd0 : tap_q;
            word_valid        = gen_en && (dense || ($urandom_range(3) != 0));
            data_in_to_device = lane_mask[tap_q] ? rotr(SYNC, lane_rot) : rand_bad();
        end
    end

    // Widest run of passing taps, earliest on ties.
    function automatic void ref_eye(input logic [31:0] m, output int bs, output int bl);
        int cur;
        cur = 0; bs = 0; bl = 0;
        for (int t = 0; t < 32; t++) begin
            cur = m[t] ? cur + 1 : 0;
            if (cur > bl) begin
                bl = cur;
                bs = t - cur + 1;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_lock"},  locked, 0);
        chk({tag, "_fail"},  fail, 0);
        chk({tag, "_err"},   err_code, 0);
        chk({tag, "_estart"}, eye_start, 0);
        chk({tag, "_elen"},  eye_len, 0);
        chk({tag, "_rot"},   word_rot, 0);
        chk({tag, "_ld"},    ld_dly_tap, 0);
        chk({tag, "_tapin"}, in_delay_tap_in, 0);
        chk({tag, "_ceinc"}, {in_delay_data_ce, in_delay_data_inc}, 0);
    endtask

    task automatic run_train(input string tag, input logic [31:0] mask, input int rot,
                             input bit mid_start);
        int bs, bl, budget, bad;
        bit ok;
        logic [31:0] eff;
        lane_mask = mask; lane_rot = rot; gen_en = 1'b1; dense = 1'b0;
        loads.delete();
        pulse_start();
        budget = 0;
        while (!(locked || fail) && budget < 20000) begin
            @(negedge clk);
            budget++;
            start = (mid_start && budget == 300);
        end
        start = 1'b0;
        chk({tag, "_tmo"}, budget < 20000, 1);
        eff = (ROT_EN || rot == 0) ? mask : 32'd0;
        ref_eye(eff, bs, bl);
        ok = (bl >= MIN_EYE);
        chk({tag, "_locked"}, locked, ok);
        chk({tag, "_fail"},   fail, !ok);
        chk({tag, "_err"},    err_code, ok ? 0 : 1);
        chk({tag, "_estart"}, eye_start, bs);
        chk({tag, "_elen"},   eye_len, bl);
        chk({tag, "_rot"},    word_rot, (ok && ROT_EN) ? rot : 0);
        chk({tag, "_busy"},   busy, 0);
        bad = 0;
        for (int i = 0; i < 32 && i < loads.size(); i++)
            if (loads[i] != i) bad++;
        chk({tag, "_seq"}, bad, 0);
        chk({tag, "_nld"}, loads.size(), ok ? 33 : 32);
        if (ok && loads.size() == 33) chk({tag, "_final"}, loads[32], bs + bl / 2);
    endtask

    initial begin
        int n;
        logic [31:0] m;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        run_train("w10_17", 32'h0003FC00, 0, 1'b1);
        run_train("tie",    32'h00F00078, 0, 1'b0);
        run_train("top",    32'hF0000000, 0, 1'b0);
        run_train("narrow", 32'h00000700, 0, 1'b0);
        run_train("rot7",   32'h00001FE0, 7, 1'b0);
        for (int k = 0; k < 2; k++) begin
            m = '0;
            for (int t = 0; t < 32; t++)
                m[t] = (t > 0 && m[t-1]) ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            run_train($sformatf("rnd%0d", k), m, 0, 1'b0);
        end

        // Word stream stops mid-training.
        lane_mask = '1; lane_rot = 0; gen_en = 1'b1; dense = 1'b1;
        loads.delete();
        pulse_start();
        n = 0;
        while (loads.size() == 0 && n < 100) begin @(negedge clk); n++; end
        chk("to_first_load", n < 100, 1);
        repeat (14) @(negedge clk);
        gen_en = 1'b0;
        repeat (TIMEOUT - 20) @(negedge clk);
        chk("to_early", fail, 0);
        n = 0;
        while (!fail && n < 100) begin @(negedge clk); n++; end
        chk("to_fail", fail, 1);
        chk("to_err",  err_code, 2);
        chk("to_busy", busy, 0);
        gen_en = 1'b1; dense = 1'b0;

        // Tap readback stuck at zero: tap 0 verifies, tap 1 cannot.
        force_bad = 1'b1;
        loads.delete();
        pulse_start();
        n = 0;
        while (!fail && n < 3000) begin @(negedge clk); n++; end
        chk("rb_fail",   fail, 1);
        chk("rb_err",    err_code, 3);
        chk("rb_locked", locked, 0);
        chk("rb_nld",    loads.size(), 2);
        force_bad = 1'b0;

        // Reset lands on the cycle that would load tap 12.
        lane_mask = 32'h00000078;
        loads.delete();
        pulse_start();
        n = 0;
        while (!(ld_dly_tap && in_delay_tap_in == 5'd12) && n < 5000) begin @(negedge clk); n++; end
        chk("rst_reach", n < 5000, 1);
        chk("rst_pre_elen", eye_len, 4);
        rst = 1'b1;
        #1;
        chk("rst_ld_gate", ld_dly_tap, 0);
        @(posedge clk);
        @(negedge clk);
        chk_idle("rst_mid");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_noload", loads.size(), 12);
        chk("rst_stay_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
